// File: rtl/mem_stage.sv
// MEM stage: runs loads/stores on a req/ack data bus, stalls the
// pipeline while an access is outstanding, resolves branches and
// registers the MEM/WB bundle.
//
// Ports:
//   CLOCK, RESET               clock, synchronous active-high reset
//   *_In                       EX/MEM bundle (controls, ALU result,
//                              store data, destination, branch target)
//   MemReq/MemWE/MemAddr/
//   MemWData                   registered bus request
//   MemRData/MemAck            bus response, sampled only in ACCESS
//   Stall                      combinational upstream freeze
//   PCSrc/BranchTarget         combinational branch resolution
//   MemError                   sticky misalignment/timeout flag
//   *_Out                      MEM/WB bundle
module mem_stage #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        RegWriteEN_In,
    input  logic        Mem2RegSEL_In,
    input  logic        MemWriteEN_In,
    input  logic        Branch_In,
    input  logic        ZeroFlag_In,
    input  logic [31:0] ALUResult_In,
    input  logic [31:0] WriteData_In,
    input  logic [31:0] WriteReg_In,
    input  logic [31:0] PC_In,
    output logic        MemReq,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck,
    output logic        Stall,
    output logic        PCSrc,
    output logic [31:0] BranchTarget,
    output logic        MemError,
    output logic        RegWriteEN_Out,
    output logic        Mem2RegSEL_Out,
    output logic [31:0] ReadData_Out,
    output logic [31:0] ALUResult_Out,
    output logic [31:0] WriteReg_Out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] counter;

    logic mem_op;
    logic is_store;
    logic is_load;
    logic misaligned;
    logic timeout_hit;

    // Per-cycle actions decided by the FSM.
    logic start;
    logic retire;
    logic acked;
    logic fault;
    logic bubble;

    // A store wins when both load and store controls are set.
    assign mem_op      = Mem2RegSEL_In | MemWriteEN_In;
    assign is_store    = MemWriteEN_In;
    assign is_load     = Mem2RegSEL_In & ~MemWriteEN_In;
    assign misaligned  = mem_op & (ALUResult_In[1:0] != 2'b00);
    assign timeout_hit = (counter == CNT_W'(ACK_TIMEOUT - 1));

    assign PCSrc        = Branch_In & ZeroFlag_In;
    assign BranchTarget = PC_In;

    always_comb begin
        next_state = state;
        Stall      = 1'b0;
        start      = 1'b0;
        retire     = 1'b0;
        acked      = 1'b0;
        fault      = 1'b0;
        bubble     = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    Stall      = 1'b1;
                    start      = 1'b1;
                    bubble     = 1'b1;
                    next_state = ACCESS;
                end else begin
                    retire = 1'b1;
                    fault  = misaligned;
                end
            end
            ACCESS: begin
                if (MemAck) begin
                    retire     = 1'b1;
                    acked      = 1'b1;
                    next_state = IDLE;
                end else if (timeout_hit) begin
                    // Forced completion: write-back is suppressed.
                    retire     = 1'b1;
                    fault      = 1'b1;
                    next_state = IDLE;
                end else begin
                    Stall  = 1'b1;
                    bubble = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            counter  <= '0;
            MemReq   <= 1'b0;
            MemWE    <= 1'b0;
            MemAddr  <= 32'h0;
            MemWData <= 32'h0;
            MemError <= 1'b0;
        end else begin
            if (start) begin
                counter  <= '0;
                MemReq   <= 1'b1;
                MemWE    <= MemWriteEN_In;
                MemAddr  <= ALUResult_In;
                MemWData <= WriteData_In;
            end else if (state == ACCESS) begin
                if (retire) begin
                    MemReq <= 1'b0;
                end else begin
                    counter <= counter + 1'b1;
                end
            end
            if (fault) begin
                MemError <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            RegWriteEN_Out <= 1'b0;
            Mem2RegSEL_Out <= 1'b0;
            ReadData_Out   <= 32'h0;
            ALUResult_Out  <= 32'h0;
            WriteReg_Out   <= 32'h0;
        end else if (retire) begin
            RegWriteEN_Out <= RegWriteEN_In & ~is_store & ~fault;
            Mem2RegSEL_Out <= is_load;
            ReadData_Out   <= (acked && is_load) ? MemRData : 32'h0;
            ALUResult_Out  <= ALUResult_In;
            WriteReg_Out   <= WriteReg_In;
        end else if (bubble) begin
            RegWriteEN_Out <= 1'b0;
            Mem2RegSEL_Out <= 1'b0;
            ReadData_Out   <= 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scoreboard of expected MEM/WB bundles pushed
// at issue and popped when the stage retires the operation.
module tb_mem_stage;

    localparam int ACK_TIMEOUT = 16;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In;
    logic        Branch_In, ZeroFlag_In;
    logic [31:0] ALUResult_In, WriteData_In, WriteReg_In, PC_In;
    logic        MemReq, MemWE;
    logic [31:0] MemAddr, MemWData, MemRData;
    logic        MemAck, Stall, PCSrc, MemError;
    logic [31:0] BranchTarget;
    logic        RegWriteEN_Out, Mem2RegSEL_Out;
    logic [31:0] ReadData_Out, ALUResult_Out, WriteReg_Out;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [31:0] wr;
    } mwb_t;

    mwb_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic err_e = 1'b0;

    mem_stage #(.ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(5)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .RegWriteEN_In(RegWriteEN_In), .Mem2RegSEL_In(Mem2RegSEL_In),
        .MemWriteEN_In(MemWriteEN_In), .Branch_In(Branch_In),
        .ZeroFlag_In(ZeroFlag_In), .ALUResult_In(ALUResult_In),
        .WriteData_In(WriteData_In), .WriteReg_In(WriteReg_In),
        .PC_In(PC_In), .MemReq(MemReq), .MemWE(MemWE),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData),
        .MemAck(MemAck), .Stall(Stall), .PCSrc(PCSrc),
        .BranchTarget(BranchTarget), .MemError(MemError),
        .RegWriteEN_Out(RegWriteEN_Out), .Mem2RegSEL_Out(Mem2RegSEL_Out),
        .ReadData_Out(ReadData_Out), .ALUResult_Out(ALUResult_Out),
        .WriteReg_Out(WriteReg_Out)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        RegWriteEN_In = 1'b0;
        Mem2RegSEL_In = 1'b0;
        MemWriteEN_In = 1'b0;
        Branch_In     = 1'b0;
        ZeroFlag_In   = 1'b0;
        ALUResult_In  = 32'h0;
        WriteData_In  = 32'h0;
        WriteReg_In   = 32'h0;
        PC_In         = 32'h0;
        MemAck        = 1'b0;
        MemRData      = 32'h0;
    endtask

    // ack_after: ACCESS cycle index (0 = first) carrying MemAck; <0 = none.
    task automatic run_op(input logic rw, input logic m2r, input logic mw,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [31:0] wr, input int ack_after,
                          input logic [31:0] rdata);
        mwb_t e;
        mwb_t g;
        logic memop, mis, tmo, load, st, done, req_seen;
        int   exp_stalls, stalls, acc;
        load  = m2r & ~mw;
        memop = m2r | mw;
        mis   = memop && (alu[1:0] != 2'b00);
        tmo   = memop && !mis && (ack_after < 0 || ack_after >= ACK_TIMEOUT);
        e.rw  = rw & ~mw & ~mis & ~tmo;
        e.m2r = load;
        e.rd  = (memop && !mis && !tmo && load) ? rdata : 32'h0;
        e.alu = alu;
        e.wr  = wr;
        exp_stalls = (memop && !mis) ?
                     1 + (tmo ? ACK_TIMEOUT - 1 : ack_after) : 0;
        err_e = err_e | mis | tmo;
        sb.push_back(e);

        @(negedge CLOCK);
        RegWriteEN_In = rw;
        Mem2RegSEL_In = m2r;
        MemWriteEN_In = mw;
        ALUResult_In  = alu;
        WriteData_In  = wd;
        WriteReg_In   = wr;
        stalls = 0;
        acc = 0;
        done = 1'b0;
        req_seen = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) @(negedge CLOCK);
            if (MemReq) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    chk("mem_addr", MemAddr, alu);
                    chk("mem_we", 32'(MemWE), 32'(mw));
                    if (mw) chk("mem_wdata", MemWData, wd);
                end
                MemAck   = (acc == ack_after);
                MemRData = (acc == ack_after) ? rdata : 32'h0BAD0BAD;
                acc++;
            end else begin
                MemAck = 1'b0;
            end
            #1;
            st = Stall;
            if (st) stalls++;
            @(posedge CLOCK);
            #1;
            if (st) begin
                chk("bubble_rw", 32'(RegWriteEN_Out), 32'h0);
                chk("bubble_m2r", 32'(Mem2RegSEL_Out), 32'h0);
            end else begin
                done = 1'b1;
                g = sb.pop_front();
                chk("wb_rw", 32'(RegWriteEN_Out), 32'(g.rw));
                chk("wb_m2r", 32'(Mem2RegSEL_Out), 32'(g.m2r));
                chk("wb_rdata", ReadData_Out, g.rd);
                chk("wb_alu", ALUResult_Out, g.alu);
                chk("wb_reg", WriteReg_Out, g.wr);
                chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
                chk("req_seen", 32'(req_seen), 32'(memop && !mis));
                chk("req_low_after", 32'(MemReq), 32'h0);
                chk("mem_error", 32'(MemError), 32'(err_e));
            end
        end
        chk("op_done", 32'(done), 32'h1);
        @(negedge CLOCK);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        RESET = 1'b1;
        @(posedge CLOCK);
        @(posedge CLOCK);
        #1;
        chk("rst_req", 32'(MemReq), 32'h0);
        chk("rst_err", 32'(MemError), 32'h0);
        chk("rst_rw", 32'(RegWriteEN_Out), 32'h0);
        chk("rst_alu", ALUResult_Out, 32'h0);
        chk("rst_addr", MemAddr, 32'h0);
        @(negedge CLOCK);
        RESET = 1'b0;

        // ALU op, load with ack on 4th ACCESS cycle, store immediate ack.
        run_op(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 32'd5, -1, 32'h0);
        run_op(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'd7, 3, 32'hDEADBEEF);
        run_op(1'b1, 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 32'd9, 0,
               32'h0);
        // Back-to-back loads, then a store with both controls set.
        run_op(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 32'd3, 0, 32'h13572468);
        run_op(1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 32'd4, 1, 32'hA5A5A5A5);
        run_op(1'b1, 1'b1, 1'b1, 32'hC0, 32'h11112222, 32'd6, 2,
               32'h0);
        // Misaligned load, then an ALU op with the error still sticky.
        run_op(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 32'd8, 0, 32'h55555555);
        run_op(1'b1, 1'b0, 1'b0, 32'hABCD, 32'h0, 32'd10, -1, 32'h0);
        // Load that never gets acked: forced completion.
        run_op(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'd11, -1, 32'h0);

        // Branch resolution.
        @(negedge CLOCK);
        Branch_In   = 1'b1;
        ZeroFlag_In = 1'b1;
        PC_In       = 32'h100;
        #1;
        chk("pcsrc_taken", 32'(PCSrc), 32'h1);
        chk("btarget", BranchTarget, 32'h100);
        chk("branch_nostall", 32'(Stall), 32'h0);
        ZeroFlag_In = 1'b0;
        #1;
        chk("pcsrc_not_taken", 32'(PCSrc), 32'h0);
        clear_inputs();

        // Reset during ACCESS, followed by a late ack.
        @(negedge CLOCK);
        RegWriteEN_In = 1'b1;
        Mem2RegSEL_In = 1'b1;
        ALUResult_In  = 32'h60;
        WriteReg_In   = 32'd12;
        @(posedge CLOCK);
        #1;
        chk("rst_mid_req_pre", 32'(MemReq), 32'h1);
        @(negedge CLOCK);
        RESET = 1'b1;
        @(posedge CLOCK);
        #1;
        chk("rst_mid_req", 32'(MemReq), 32'h0);
        chk("rst_mid_we", 32'(MemWE), 32'h0);
        chk("rst_mid_addr", MemAddr, 32'h0);
        chk("rst_mid_err", 32'(MemError), 32'h0);
        chk("rst_mid_rw", 32'(RegWriteEN_Out), 32'h0);
        chk("rst_mid_wreg", WriteReg_Out, 32'h0);
        chk("rst_mid_alu", ALUResult_Out, 32'h0);
        err_e = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b0;
        clear_inputs();
        MemAck   = 1'b1;
        MemRData = 32'hFFFFFFFF;
        #1;
        chk("late_ack_stall", 32'(Stall), 32'h0);
        @(posedge CLOCK);
        #1;
        chk("late_ack_req", 32'(MemReq), 32'h0);
        chk("late_ack_rdata", ReadData_Out, 32'h0);
        chk("late_ack_err", 32'(MemError), 32'h0);
        @(negedge CLOCK);
        MemAck = 1'b0;

        // Normal operation after reset.
        run_op(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 32'd2, 0, 32'h600DF00D);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
